crc_rx_checker: RTL and testbench



---
 rtl/crc_rx_checker.sv | 187 ++++++++++++++++++
 tb/tb_crc_rx_checker.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/crc_rx_checker.sv
// Serial CRC receive checker: deserialises an LSB-first payload, recomputes a reflected CRC and
// compares it against the trailing received CRC. Optional syndrome output under CRC_RX_SYNDROME_EN.
//
// state  | meaning
// S_IDLE | waiting for the first qualified payload bit
// S_DATA | shifting payload bits, LFSR updated per data_en cycle
// S_CRC  | comparing received CRC bits against the LFSR, one per crc_en cycle
// S_DONE | single cycle; results and frame_done registered on its closing edge
module crc_rx_checker #(
   parameter int                     DATA_WIDTH = 8,
   parameter int                     CRC_WIDTH  = 8,
   parameter logic [CRC_WIDTH-1:0]   POLY       = 8'h8C,
   parameter logic [CRC_WIDTH-1:0]   SEED       = 8'h00
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  serial_in,
   input  logic                  data_en,
   input  logic                  crc_en,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  frame_done,
   output logic                  crc_ok,
   output logic                  crc_err,
`ifdef CRC_RX_SYNDROME_EN
   output logic [CRC_WIDTH-1:0]  syndrome,
`endif
   output logic                  busy
);

   localparam int MAX_W = (DATA_WIDTH > CRC_WIDTH) ? DATA_WIDTH : CRC_WIDTH;
   localparam int CNT_W = $clog2(MAX_W) + 1;
   localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_WIDTH - 1);
   localparam logic [CNT_W-1:0] CRC_LAST  = CNT_W'(CRC_WIDTH - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_DATA = 2'd1,
      S_CRC  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t                state_q,    state_d;
   logic [CNT_W-1:0]      cnt_q,      cnt_d;
   logic [CRC_WIDTH-1:0]  lfsr_q,     lfsr_d;
   logic [DATA_WIDTH-1:0] shreg_q,    shreg_d;
   logic                  mism_q,     mism_d;
   logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
   logic                  done_q,     done_d;
   logic                  ok_q,       ok_d;
   logic                  err_q,      err_d;
`ifdef CRC_RX_SYNDROME_EN
   logic [CRC_WIDTH-1:0]  syn_sh_q,   syn_sh_d;
   logic [CRC_WIDTH-1:0]  syn_q,      syn_d;
`endif

   logic                  fb_run;
   logic                  fb_first;
   logic [CRC_WIDTH-1:0]  lfsr_run;
   logic [CRC_WIDTH-1:0]  lfsr_first;
   logic [DATA_WIDTH-1:0] shreg_shift;
   logic                  crc_bit_err;

   // The first payload bit advances from SEED directly, so the frame never depends on stale LFSR state.
   always_comb begin
      fb_run      = serial_in ^ lfsr_q[0];
      fb_first    = serial_in ^ SEED[0];
      lfsr_run    = (lfsr_q >> 1) ^ (fb_run   ? POLY : '0);
      lfsr_first  = (SEED   >> 1) ^ (fb_first ? POLY : '0);
      shreg_shift = (shreg_q >> 1) | (DATA_WIDTH'(serial_in) << (DATA_WIDTH - 1));
      crc_bit_err = serial_in ^ lfsr_q[0];
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      lfsr_d     = lfsr_q;
      shreg_d    = shreg_q;
      mism_d     = mism_q;
      data_out_d = data_out_q;
      done_d     = 1'b0;
      ok_d       = ok_q;
      err_d      = err_q;
`ifdef CRC_RX_SYNDROME_EN
      syn_sh_d   = syn_sh_q;
      syn_d      = syn_q;
`endif
      unique case (state_q)
         S_IDLE: begin
            if (data_en) begin
               lfsr_d  = lfsr_first;
               shreg_d = shreg_shift;
               mism_d  = 1'b0;
               if (DATA_LAST == '0) begin
                  cnt_d   = '0;
                  state_d = S_CRC;
               end else begin
                  cnt_d   = CNT_W'(1);
                  state_d = S_DATA;
               end
            end
         end
         S_DATA: begin
            if (data_en) begin
               lfsr_d  = lfsr_run;
               shreg_d = shreg_shift;
               if (cnt_q == DATA_LAST) begin
                  cnt_d   = '0;
                  state_d = S_CRC;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
         end
         S_CRC: begin
            if (crc_en) begin
               mism_d = mism_q | crc_bit_err;
               lfsr_d = lfsr_q >> 1;
`ifdef CRC_RX_SYNDROME_EN
               syn_sh_d = (syn_sh_q >> 1) | (CRC_WIDTH'(crc_bit_err) << (CRC_WIDTH - 1));
`endif
               if (cnt_q == CRC_LAST) begin
                  cnt_d   = '0;
                  state_d = S_DONE;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
         end
         S_DONE: begin
            done_d     = 1'b1;
            data_out_d = shreg_q;
            ok_d       = ~mism_q;
            err_d      = mism_q;
`ifdef CRC_RX_SYNDROME_EN
            syn_d      = syn_sh_q;
`endif
            state_d    = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         lfsr_q     <= SEED;
         shreg_q    <= '0;
         mism_q     <= 1'b0;
         data_out_q <= '0;
         done_q     <= 1'b0;
         ok_q       <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         lfsr_q     <= lfsr_d;
         shreg_q    <= shreg_d;
         mism_q     <= mism_d;
         data_out_q <= data_out_d;
         done_q     <= done_d;
         ok_q       <= ok_d;
         err_q      <= err_d;
      end
   end

`ifdef CRC_RX_SYNDROME_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         syn_sh_q <= '0;
         syn_q    <= '0;
      end else begin
         syn_sh_q <= syn_sh_d;
         syn_q    <= syn_d;
      end
   end

   assign syndrome = syn_q;
`endif

   assign data_out   = data_out_q;
   assign frame_done = done_q;
   assign crc_ok     = ok_q;
   assign crc_err    = err_q;
   assign busy       = (state_q == S_DATA) || (state_q == S_CRC);

endmodule

// File: tb/tb_crc_rx_checker.sv
// Scoreboard bench for crc_rx_checker: driver pushes expected frame results, a negedge monitor pops
// and compares on every frame_done. Reference CRC is the textbook byte-wise reflected CRC-8.
module tb_crc_rx_checker;

   localparam logic [7:0] POLY = 8'h8C;
   localparam logic [7:0] SEED = 8'h00;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       serial_in = 1'b0;
   logic       data_en = 1'b0;
   logic       crc_en = 1'b0;
   logic [7:0] data_out;
   logic       frame_done;
   logic       crc_ok;
   logic       crc_err;
   logic       busy;
`ifdef CRC_RX_SYNDROME_EN
   logic [7:0] syndrome;
`endif

   crc_rx_checker #(
      .DATA_WIDTH(8), .CRC_WIDTH(8), .POLY(POLY), .SEED(SEED)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .serial_in (serial_in),
      .data_en   (data_en),
      .crc_en    (crc_en),
      .data_out  (data_out),
      .frame_done(frame_done),
      .crc_ok    (crc_ok),
      .crc_err   (crc_err),
`ifdef CRC_RX_SYNDROME_EN
      .syndrome  (syndrome),
`endif
      .busy      (busy)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [7:0] data;
      logic       ok;
      logic [7:0] syn;
      int         done_cyc;
   } exp_t;

   exp_t q[$];
   int   total = 0;
   int   bad = 0;
   logic done_prev = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [7:0] ref_crc(input logic [7:0] d);
      logic [7:0] c;
      c = SEED ^ d;
      for (int i = 0; i < 8; i++) c = c[0] ? ((c >> 1) ^ POLY) : (c >> 1);
      return c;
   endfunction

   always @(negedge clk) begin
      exp_t e;
      if (frame_done) begin
         chk("done_width", {31'b0, done_prev}, 32'd0);
         if (q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_done: frame_done with no frame pending (cycle %0d)", cyc);
         end else begin
            e = q.pop_front();
            chk("data_out", {24'b0, data_out}, {24'b0, e.data});
            chk("crc_ok", {31'b0, crc_ok}, {31'b0, e.ok});
            chk("crc_err", {31'b0, crc_err}, {31'b0, ~e.ok});
            chk("done_cycle", cyc, e.done_cyc);
`ifdef CRC_RX_SYNDROME_EN
            chk("syndrome", {24'b0, syndrome}, {24'b0, e.syn});
`endif
         end
      end
      done_prev = frame_done;
   end

   task automatic drive(input logic s, input logic de, input logic ce);
      @(posedge clk);
      #1;
      serial_in = s;
      data_en   = de;
      crc_en    = ce;
   endtask

   task automatic chk_all_zero(input string name);
      chk(name, {19'b0, data_out, frame_done, crc_ok, crc_err, busy}, 32'd0);
   endtask

   // Frame = 8 payload bits then 8 CRC bits, LSB first; nstall idle cycles inserted at one mid-frame point.
   task automatic send_frame(input logic [7:0] d, input logic [7:0] c, input int nstall,
                             input bit noise, input int idle_pre);
      logic [15:0] bits;
      int          stall_pos;
      exp_t        e;
      bits      = {c, d};
      stall_pos = (nstall > 0) ? int'($urandom_range(1, 15)) : 99;
      for (int i = 0; i < idle_pre; i++) drive(1'($urandom), 1'b0, noise);
      for (int i = 0; i < 16; i++) begin
         if (i == stall_pos)
            for (int k = 0; k < nstall; k++)
               drive(1'($urandom), noise && (i >= 8), noise && (i < 8));
         drive(bits[i], i < 8, i >= 8);
         if (i == 0) begin
            e.data     = d;
            e.ok       = (c == ref_crc(d));
            e.syn      = c ^ ref_crc(d);
            e.done_cyc = cyc + 17 + nstall;
            q.push_back(e);
         end
         if (i == 1) chk("busy_in_frame", {31'b0, busy}, 32'd1);
      end
      drive(1'b0, 1'b0, 1'b0);
      drive(1'b0, 1'b0, 1'b0);
      chk("busy_after_frame", {31'b0, busy}, 32'd0);
   endtask

   initial begin
      logic [7:0] d;
      logic [7:0] c;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         drive(1'b0, 1'b0, 1'b0);
         chk_all_zero("idle_after_reset");
      end

      send_frame(8'h01, 8'h5E, 0, 1'b0, 1);
      send_frame(8'h01, 8'h5F, 0, 1'b0, 1);
      send_frame(8'h00, 8'h00, 3, 1'b0, 1);
      send_frame(8'h01, 8'h5E, 3, 1'b1, 3);

      // Abort after 4 payload bits: no frame_done may follow, outputs drop to reset values.
      for (int i = 0; i < 4; i++) drive(1'b1, 1'b1, 1'b0);
      @(posedge clk);
      #1 rst_n = 1'b0;
      data_en = 1'b0;
      #1 chk_all_zero("outputs_in_reset");
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      drive(1'b0, 1'b0, 1'b0);
      chk_all_zero("outputs_after_abort");
      send_frame(8'h01, 8'h5E, 0, 1'b0, 1);

      for (int n = 0; n < 24; n++) begin
         d = 8'($urandom);
         c = ref_crc(d);
         if ($urandom_range(0, 1) == 1) c = c ^ (8'h01 << $urandom_range(0, 7));
         send_frame(d, c, int'($urandom_range(0, 3)), 1'($urandom), int'($urandom_range(0, 3)));
      end

      repeat (30) drive(1'b0, 1'b0, 1'b0);
      chk("queue_drained", q.size(), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: bench did not finish (cycle %0d)", cyc);
      $fatal(1);
   end

endmodule
